debug_run_ctrl: RTL

Run-control sequencer for the Hack CPU debug path. It gates the CPU clock enable to run, halt and single-step at instruction boundaries, and stops on a 16-bit PC breakpoint. It also keeps a coherent snapshot of regD/regA/pc/state for the SPI debug slave, which reads it asynchronously on sclk. Commands arrive from the debug command decoder over a valid/ready handshake.

---
 rtl/debug_run_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/debug_run_ctrl.sv
// Run-control sequencer for the Hack CPU debug path.
// Gates the CPU clock enable for run / halt / single-step at instruction
// boundaries, stops on a PC breakpoint, and maintains a snapshot of the
// CPU registers that stays frozen while the SPI slave has chip select low.
module debug_run_ctrl #(
  parameter bit RUN_AT_RESET = 1'b0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk_i,
  input  logic        resetb,
  input  logic        cmd_valid_i,
  input  logic [2:0]  cmd_i,
  input  logic [15:0] cmd_data_i,
  output logic        cmd_ready_o,
  output logic        cmd_err_o,
  input  logic        instr_done_i,
  input  logic [15:0] pc_i,
  input  logic [15:0] regD_i,
  input  logic [15:0] regA_i,
  input  logic [1:0]  state_i,
  output logic        cpu_en_o,
  input  logic        spi_csb_i,
  output logic [15:0] snap_regD_o,
  output logic [15:0] snap_regA_o,
  output logic [15:0] snap_pc_o,
  output logic [1:0]  snap_state_o,
  output logic        halted_o,
  output logic        bp_hit_o
);

  localparam logic [2:0] C_HALT  = 3'd1;
  localparam logic [2:0] C_RUN   = 3'd2;
  localparam logic [2:0] C_STEP  = 3'd3;
  localparam logic [2:0] C_SETBP = 3'd4;
  localparam logic [2:0] C_CLRBP = 3'd5;
  localparam logic [2:0] C_SNAP  = 3'd6;
  localparam logic [2:0] C_RSV   = 3'd7;

  typedef enum logic [2:0] {
    S_RUN, S_HALTING, S_HALTED, S_STEPPING, S_CHECK
  } state_t;

  localparam state_t S_RST = RUN_AT_RESET ? S_RUN : S_HALTED;

  state_t                 r_state;
  logic                   r_cpu_en;
  logic                   r_err;
  logic                   r_bp_hit;
  logic                   r_bp_en;
  logic [15:0]            r_bp_addr;
  logic                   r_snap_pending;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [15:0]            r_snap_regD, r_snap_regA, r_snap_pc;
  logic [1:0]             r_snap_state;

  logic w_ready, w_acc, w_csb_s, w_snap_load;

  // HALTING/STEPPING wait for the instruction boundary and refuse new commands
  assign w_ready     = (r_state == S_RUN) || (r_state == S_HALTED) || (r_state == S_CHECK);
  assign w_acc       = cmd_valid_i && w_ready;
  assign w_csb_s     = r_sync[SYNC_STAGES-1];
  assign w_snap_load = r_snap_pending && w_csb_s;

  assign cmd_ready_o  = w_ready;
  assign cmd_err_o    = r_err;
  assign cpu_en_o     = r_cpu_en;
  assign halted_o     = (r_state == S_HALTED);
  assign bp_hit_o     = r_bp_hit;
  assign snap_regD_o  = r_snap_regD;
  assign snap_regA_o  = r_snap_regA;
  assign snap_pc_o    = r_snap_pc;
  assign snap_state_o = r_snap_state;

  // Run-control FSM; cpu_en drops on the same edge that samples instr_done
  always_ff @(posedge clk_i or negedge resetb) begin
    if (!resetb) begin
      r_state        <= S_RST;
      r_cpu_en       <= RUN_AT_RESET;
      r_err          <= 1'b0;
      r_bp_hit       <= 1'b0;
      r_snap_pending <= 1'b0;
    end else begin
      r_err <= w_acc && ((cmd_i == C_RSV) || ((cmd_i == C_STEP) && (r_state != S_HALTED)));
      // a fresh request (below) wins over the clear from a load this cycle
      if (w_snap_load)                  r_snap_pending <= 1'b0;
      if (w_acc && (cmd_i == C_SNAP))   r_snap_pending <= 1'b1;
      case (r_state)
        S_RUN: begin
          if (w_acc && (cmd_i == C_HALT)) begin
            if (instr_done_i) begin
              r_state        <= S_HALTED;
              r_cpu_en       <= 1'b0;
              r_snap_pending <= 1'b1;
            end else begin
              r_state <= S_HALTING;
            end
          end else if (instr_done_i && r_bp_en) begin
            r_state  <= S_CHECK;
            r_cpu_en <= 1'b0;
          end
        end
        S_HALTING, S_STEPPING: begin
          if (instr_done_i) begin
            r_state        <= S_HALTED;
            r_cpu_en       <= 1'b0;
            r_snap_pending <= 1'b1;
          end
        end
        S_HALTED: begin
          if (w_acc && (cmd_i == C_RUN)) begin
            r_state  <= S_RUN;
            r_cpu_en <= 1'b1;
            r_bp_hit <= 1'b0;
          end else if (w_acc && (cmd_i == C_STEP)) begin
            r_state  <= S_STEPPING;
            r_cpu_en <= 1'b1;
          end
        end
        S_CHECK: begin
          // pc_i already holds the next instruction address here
          if (w_acc && (cmd_i == C_HALT)) begin
            r_state        <= S_HALTED;
            r_snap_pending <= 1'b1;
          end else if (pc_i == r_bp_addr) begin
            r_state        <= S_HALTED;
            r_bp_hit       <= 1'b1;
            r_snap_pending <= 1'b1;
          end else begin
            r_state  <= S_RUN;
            r_cpu_en <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_RST;
          r_cpu_en <= RUN_AT_RESET;
        end
      endcase
    end
  end

  // Breakpoint register, updated the cycle after SETBP/CLRBP is accepted
  always_ff @(posedge clk_i or negedge resetb) begin
    if (!resetb) begin
      r_bp_en   <= 1'b0;
      r_bp_addr <= 16'h0000;
    end else if (w_acc && (cmd_i == C_SETBP)) begin
      r_bp_en   <= 1'b1;
      r_bp_addr <= cmd_data_i;
    end else if (w_acc && (cmd_i == C_CLRBP)) begin
      r_bp_en   <= 1'b0;
    end
  end

  // Chip-select synchroniser, idles high (deselected)
  always_ff @(posedge clk_i or negedge resetb) begin
    if (!resetb) r_sync <= '1;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], spi_csb_i};
  end

  // Snapshot only moves while the SPI slave is deselected
  always_ff @(posedge clk_i or negedge resetb) begin
    if (!resetb) begin
      r_snap_regD  <= 16'h0000;
      r_snap_regA  <= 16'h0000;
      r_snap_pc    <= 16'h0000;
      r_snap_state <= 2'b00;
    end else if (w_snap_load) begin
      r_snap_regD  <= regD_i;
      r_snap_regA  <= regA_i;
      r_snap_pc    <= pc_i;
      r_snap_state <= state_i;
    end
  end

endmodule
